bomb_controller: RTL
====================

BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 Parameter: FUSE_MAX, default 150000000, clk cycles from bomb placement to detonation.
REQ-002 Parameter: EXP_MAX, default 50000000, clk cycles the explosion stays displayed.
REQ-003 clk  input  1  system clock; one clock domain.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 x, y  input  10 each  current VGA pixel location.
REQ-006 x_b, y_b  input  10 each  bomberman sprite top-left, screen coordinates.
REQ-007 A  input  1  controller place-bomb button, level.
REQ-008 gameover  input  1  asserted when game lives == 0.
REQ-009 clr_ack  input  1  block-map clear acknowledge.
REQ-010 clr_req  output  1  block-map clear request.
REQ-011 clr_col, clr_row  output  6 / 5  tile to clear; valid while clr_req = 1.
REQ-012 bomb_active  output  1  high in FUSE.
REQ-013 exp_active  output  1  high in CLEAR and EXPLODE.
REQ-014 bomb_col, bomb_row  output  6 / 5  registered bomb tile.
REQ-015 bomb_on, exp_on  output  1 each  pixel (x, y) lies in the bomb tile or an explosion tile.

Function
REQ-016 Arena geometry: origin (48, 32); 16-px tiles; 33 columns (0..32) x 26 rows (0..25); pillar tile = odd col AND odd row.
REQ-017 Placement tile is computed from the hitbox centre: col = (x_b - 40) >> 4, row = (y_b - 15) >> 4, using 10-bit unsigned arithmetic, truncated to 6 / 5 bits.
REQ-018 The FSM has four states: IDLE, FUSE, CLEAR, EXPLODE.
REQ-019 A is rising-edge detected with one register; only the detected edge places a bomb.
REQ-020 IDLE -> FUSE on an A edge with gameover = 0. On that edge, bomb_col/bomb_row latch the REQ-017 tile and the timer clears to 0.
REQ-021 FUSE: the timer increments each cycle. When timer == FUSE_MAX - 1, the FSM goes to CLEAR with dir = 0 and timer = 0.
REQ-022 CLEAR visits directions in the order dir 0..3 = up, right, down, left. Each target is the bomb tile +/-1 in that axis.
REQ-023 A target is valid iff it lies inside REQ-016 bounds and is not a pillar. Wrap-around (col 0 - 1, row 0 - 1) is invalid. Each direction's valid bit is registered for exp_on.
REQ-024 Invalid target: clr_req stays low and dir advances after exactly 1 cycle.
REQ-025 Valid target: clr_req rises the cycle after dir selects it. clr_req and clr_col/clr_row hold stable until clr_ack is sampled high. clr_req is low the following cycle, and dir advances.
REQ-026 clr_ack sampled while clr_req = 0 is ignored.
REQ-027 After dir 3 completes, the FSM goes to EXPLODE with timer = 0. When timer == EXP_MAX - 1 in EXPLODE, the FSM goes to IDLE.
REQ-028 A edges are ignored in FUSE, CLEAR and EXPLODE; at most one bomb exists at a time.
REQ-029 gameover only blocks placement. It does not abort FUSE, CLEAR or EXPLODE, so no handshake is ever abandoned.
REQ-030 bomb_on is combinational: bomb_active AND pixel inside the bomb tile.
REQ-031 exp_on is combinational: state EXPLODE AND pixel inside the bomb tile or inside a valid arm tile.
REQ-032 The timer is 28 bits wide and never exceeds max(FUSE_MAX, EXP_MAX) - 1.

Reset
REQ-033 With reset = 0 at a clk edge: state = IDLE, timer = 0, dir = 0, edge register = 0, valid bits = 0, clr_req = 0, clr_col = 0, clr_row = 0, bomb_col = 0, bomb_row = 0, bomb_active = 0, exp_active = 0.
REQ-034 Reset asserted mid-handshake drops clr_req the next cycle and does not wait for clr_ack.

Structure
REQ-035 A shared package holds: the arena origin (48, 32), TILE = 16, COLS = 33, ROWS = 26, the state encoding, the direction encoding (U = 0, R = 1, D = 2, L = 3, matching the cd encoding), and the hitbox offset 9.
REQ-036 One sub-module is natural: bomb_target_gen (combinational), which maps bomb tile + dir to target col/row/valid.

Verification (FUSE_MAX = 10, EXP_MAX = 5)
REQ-037 x_b = 64, y_b = 23, A pulse -> bomb tile (1, 0) latched; bomb_active high 10 cycles.
REQ-038 Bomb at (1, 0): up invalid (row -1), right (2, 0) valid, down (1, 1) pillar invalid, left (0, 0) valid. Expect exactly 2 clr_req handshakes, in order (2, 0) then (0, 0).
REQ-039 clr_ack delayed 3 cycles -> clr_req and coords stable for all 3 cycles. clr_ack pulsed in FUSE -> no effect.
REQ-040 A held high across IDLE -> exactly one bomb is placed. A edges during FUSE/EXPLODE are ignored. gameover = 1 in IDLE with an A edge -> state stays IDLE.
REQ-041 reset = 0 while clr_req is high -> next cycle clr_req = 0, state IDLE; after reset releases, a new A edge places a bomb normally.
REQ-042 Bomb at (32, 25) -> right and down are invalid (no wrap). Explosion completes, then 5 cycles of EXPLODE, then IDLE.

Source files
------------

// File: rtl/bomb_controller_pkg.sv
// Shared arena geometry, FSM state encoding and direction encoding for the bomb logic.
// Placement offsets are derived from the arena origin and the sprite hitbox.
package bomb_controller_pkg;

    localparam int ARENA_X0   = 48;
    localparam int ARENA_Y0   = 32;
    localparam int TILE       = 16;
    localparam int TILE_SHIFT = 4;
    localparam int COLS       = 33;
    localparam int ROWS       = 26;
    localparam int HITBOX_OFS = 9;

    // Hitbox centre relative to the arena origin: x_b + 8 - 48, y_b + 9 + 8 - 32
    localparam int PLACE_X_OFS = ARENA_X0 - TILE / 2;
    localparam int PLACE_Y_OFS = ARENA_Y0 - HITBOX_OFS - TILE / 2;

    localparam int ARENA_W = COLS * TILE;
    localparam int ARENA_H = ROWS * TILE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FUSE    = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_EXPLODE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_R = 2'd1,
        DIR_D = 2'd2,
        DIR_L = 2'd3
    } dir_t;

    function automatic logic is_pillar(input logic [5:0] col, input logic [4:0] row);
        return col[0] & row[0];
    endfunction

endpackage

// File: rtl/bomb_target_gen.sv
// Maps the bomb tile and a direction to the neighbouring target tile and its validity.
// Purely combinational; out-of-arena (including wrap below zero) and pillar tiles are invalid.
module bomb_target_gen
    import bomb_controller_pkg::*;
(
    input  logic [5:0] bomb_col,
    input  logic [4:0] bomb_row,
    input  dir_t       dir,
    output logic [5:0] tgt_col,
    output logic [4:0] tgt_row,
    output logic       tgt_vld
);

    logic [6:0] dc;
    logic [5:0] dr;
    logic [6:0] tc;
    logic [5:0] tr;

    // One extra bit on each axis so that 0 - 1 lands far outside the arena
    always_comb begin
        dc = 7'd0;
        dr = 6'd0;
        case (dir)
            DIR_U:   dr = 6'h3F;
            DIR_R:   dc = 7'd1;
            DIR_D:   dr = 6'd1;
            DIR_L:   dc = 7'h7F;
            default: ;
        endcase
        tc = {1'b0, bomb_col} + dc;
        tr = {1'b0, bomb_row} + dr;
    end

    assign tgt_col = tc[5:0];
    assign tgt_row = tr[4:0];
    assign tgt_vld = (tc < 7'(COLS)) && (tr < 6'(ROWS)) && !is_pillar(tgt_col, tgt_row);

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb controller: place on A edge, fuse, clear four arm tiles via req/ack, explode.
// Each arm clear holds clr_req and coordinates until clr_ack; reset abandons a pending request.
module bomb_controller
    import bomb_controller_pkg::*;
#(
    parameter int FUSE_MAX = 150000000,
    parameter int EXP_MAX  = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] x_b,
    input  logic [9:0] y_b,
    input  logic       A,
    input  logic       gameover,
    input  logic       clr_ack,
    output logic       clr_req,
    output logic [5:0] clr_col,
    output logic [4:0] clr_row,
    output logic       bomb_active,
    output logic       exp_active,
    output logic [5:0] bomb_col,
    output logic [4:0] bomb_row,
    output logic       bomb_on,
    output logic       exp_on
);

    localparam logic [27:0] FUSE_LAST = 28'(FUSE_MAX - 1);
    localparam logic [27:0] EXP_LAST  = 28'(EXP_MAX - 1);

    state_t      state, state_nxt;
    dir_t        dir;
    logic [27:0] timer;
    logic        a_q;
    logic [3:0]  arm_vld;

    logic        a_edge;
    logic        place, timer_clr, timer_inc, dir_clr, dir_adv, req_set, req_clr, vld_wr;

    logic [5:0]  tgt_col;
    logic [4:0]  tgt_row;
    logic        tgt_vld;

    bomb_target_gen u_target_gen (
        .bomb_col (bomb_col),
        .bomb_row (bomb_row),
        .dir      (dir),
        .tgt_col  (tgt_col),
        .tgt_row  (tgt_row),
        .tgt_vld  (tgt_vld)
    );

    assign a_edge = A & ~a_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        place     = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        dir_clr   = 1'b0;
        dir_adv   = 1'b0;
        req_set   = 1'b0;
        req_clr   = 1'b0;
        vld_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (a_edge && !gameover) begin
                    state_nxt = ST_FUSE;
                    place     = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            ST_FUSE: begin
                if (timer == FUSE_LAST) begin
                    state_nxt = ST_CLEAR;
                    timer_clr = 1'b1;
                    dir_clr   = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            ST_CLEAR: begin
                // Idle request slot: evaluate the current direction; otherwise wait for ack
                if (!clr_req) begin
                    vld_wr = 1'b1;
                    if (tgt_vld) begin
                        req_set = 1'b1;
                    end else begin
                        dir_adv = 1'b1;
                    end
                end else if (clr_ack) begin
                    req_clr = 1'b1;
                    dir_adv = 1'b1;
                end
                if (dir_adv && dir == DIR_L) begin
                    state_nxt = ST_EXPLODE;
                    timer_clr = 1'b1;
                end
            end
            ST_EXPLODE: begin
                if (timer == EXP_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q      <= 1'b0;
            timer    <= 28'd0;
            dir      <= DIR_U;
            arm_vld  <= 4'd0;
            clr_req  <= 1'b0;
            clr_col  <= 6'd0;
            clr_row  <= 5'd0;
            bomb_col <= 6'd0;
            bomb_row <= 5'd0;
        end else begin
            a_q <= A;
            if (place) begin
                bomb_col <= 6'((x_b - 10'(PLACE_X_OFS)) >> TILE_SHIFT);
                bomb_row <= 5'((y_b - 10'(PLACE_Y_OFS)) >> TILE_SHIFT);
            end
            if (timer_clr) begin
                timer <= 28'd0;
            end else if (timer_inc) begin
                timer <= timer + 28'd1;
            end
            if (dir_clr) begin
                dir <= DIR_U;
            end else if (dir_adv) begin
                dir <= dir_t'(dir + 2'd1);
            end
            if (vld_wr) begin
                arm_vld[dir] <= tgt_vld;
            end
            if (req_set) begin
                clr_req <= 1'b1;
                clr_col <= tgt_col;
                clr_row <= tgt_row;
            end else if (req_clr) begin
                clr_req <= 1'b0;
            end
        end
    end

    assign bomb_active = (state == ST_FUSE);
    assign exp_active  = (state == ST_CLEAR) || (state == ST_EXPLODE);

    // Pixel -> arena tile; row kept at 6 bits so the neighbour compares cannot wrap
    logic [9:0] dx, dy;
    logic       pix_in;
    logic [5:0] pix_col;
    logic [5:0] pix_row;
    logic       same_col, same_row, in_bomb, in_up, in_right, in_down, in_left;

    assign dx       = x - 10'(ARENA_X0);
    assign dy       = y - 10'(ARENA_Y0);
    assign pix_in   = (x >= 10'(ARENA_X0)) && (dx < 10'(ARENA_W)) &&
                      (y >= 10'(ARENA_Y0)) && (dy < 10'(ARENA_H));
    assign pix_col  = dx[9:4];
    assign pix_row  = dy[9:4];

    assign same_col = (pix_col == bomb_col);
    assign same_row = (pix_row == {1'b0, bomb_row});
    assign in_bomb  = same_col && same_row;
    assign in_up    = arm_vld[DIR_U] && same_col && (pix_row + 6'd1 == {1'b0, bomb_row});
    assign in_down  = arm_vld[DIR_D] && same_col && (pix_row == {1'b0, bomb_row} + 6'd1);
    assign in_right = arm_vld[DIR_R] && same_row && ({1'b0, pix_col} == {1'b0, bomb_col} + 7'd1);
    assign in_left  = arm_vld[DIR_L] && same_row && ({1'b0, pix_col} + 7'd1 == {1'b0, bomb_col});

    assign bomb_on = bomb_active && pix_in && in_bomb;
    assign exp_on  = (state == ST_EXPLODE) && pix_in &&
                     (in_bomb || in_up || in_down || in_right || in_left);

endmodule
